// File: rtl/single_cycle_datapath_if.sv
// Word-indexed data-memory bus between the core datapath and its data memory.
// The core drives index/write data/enable; the memory returns read data combinationally.
interface single_cycle_datapath_if #(
  parameter int AW = 8
);
  logic [AW-1:0] index;
  logic [31:0]   wdata;
  logic          we;
  logic [31:0]   rdata;

  modport master (output index, output wdata, output we, input rdata);
  modport slave  (input index, input wdata, input we, output rdata);
endinterface

// File: rtl/single_cycle_datapath.sv
// Single-cycle RV32I core: fetch, decode, register file, ALU, branch unit and
// data memory all resolve within one clock; PC is the only reset state.
package scd_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    WB_ALU, WB_MEM, WB_LINK, WB_IMMU, WB_AUIPC
  } wb_sel_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_write;
    logic    alu_src_imm;
    logic    imm_s;
    alu_op_e alu_op;
    wb_sel_e wb_sel;
    logic    is_branch;
    logic    is_jal;
    logic    is_jalr;
  } ctrl_t;

  // alt selects SUB/SRA; the caller only raises it where the encoding allows.
  function automatic alu_op_e alu_op_of(logic [2:0] funct3, logic alt);
    alu_op_e op;
    unique case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction
endpackage

module inst_mem #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] windex,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] index,
  output logic [31:0]   instr
);
  logic [31:0] memory [DEPTH];

  assign instr = memory[index];

  // NOTE: storage arrays carry no reset so preloaded contents survive reset;
  // a plain clocked block keeps them loadable by hierarchical reference.
  always @(posedge clock) begin
    if (we) memory[windex] <= wdata;
  end
endmodule

module reg_file (
  input  logic        clock,
  input  logic        we,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] registers [32];

  // x0 reads zero regardless of what the array slot holds.
  assign rdata1 = (rs1 == 5'd0) ? '0 : registers[rs1];
  assign rdata2 = (rs2 == 5'd0) ? '0 : registers[rs2];

  always @(posedge clock) begin
    if (we && rd != 5'd0) registers[rd] <= wdata;
  end
endmodule

module data_mem #(
  parameter int DEPTH = 256
) (
  input logic                    clock,
  single_cycle_datapath_if.slave bus
);
  logic [31:0] memory [DEPTH];

  assign bus.rdata = memory[bus.index];

  always @(posedge clock) begin
    if (bus.we) memory[bus.index] <= bus.wdata;
  end
endmodule

module alu
  import scd_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result
);
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    result = '0;
    unique case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'd0, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end
endmodule

module branch_unit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  output logic        taken
);
  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = $signed(a) < $signed(b);
      3'b101:  taken = $signed(a) >= $signed(b);
      3'b110:  taken = a < b;
      3'b111:  taken = a >= b;
      default: taken = 1'b0;
    endcase
  end
endmodule

module single_cycle_datapath
  import scd_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input logic clock,
  input logic reset
);
  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  logic [31:0] pc, pc_next, pc_plus4, instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data, alu_b, alu_result, wb_data, jalr_target;
  logic        taken;
  ctrl_t       ctrl;

  inst_mem #(.DEPTH(IMEM_DEPTH)) inst_mem_0 (
    .clock  (clock),
    .we     (1'b0),
    .windex ('0),
    .wdata  ('0),
    .index  (pc[IMEM_AW+1:2]),
    .instr  (instr)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Encodings outside the supported set fall through with ctrl all-zero: a NOP.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    ctrl.wb_sel = WB_ALU;
    unique case (opcode)
      OP_REG: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = alu_op_of(funct3, funct7[5]);
        end
      end
      OP_IMM: begin
        if ((funct3 != 3'b001 && funct3 != 3'b101) ||
            (funct3 == 3'b001 && funct7 == 7'b0000000) ||
            (funct3 == 3'b101 && (funct7 == 7'b0000000 || funct7 == 7'b0100000))) begin
          ctrl.reg_write   = 1'b1;
          ctrl.alu_src_imm = 1'b1;
          ctrl.alu_op      = alu_op_of(funct3, funct3 == 3'b101 && funct7[5]);
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          ctrl.reg_write   = 1'b1;
          ctrl.alu_src_imm = 1'b1;
          ctrl.wb_sel      = WB_MEM;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          ctrl.mem_write   = 1'b1;
          ctrl.alu_src_imm = 1'b1;
          ctrl.imm_s       = 1'b1;
        end
      end
      OP_BRANCH: ctrl.is_branch = (funct3 != 3'b010 && funct3 != 3'b011);
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_LINK;
        ctrl.is_jal    = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          ctrl.reg_write = 1'b1;
          ctrl.wb_sel    = WB_LINK;
          ctrl.is_jalr   = 1'b1;
        end
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_IMMU;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_AUIPC;
      end
      default: ctrl = '0;
    endcase
  end

  // Writes are suppressed while reset is held so no state changes under reset.
  reg_file reg_file_0 (
    .clock  (clock),
    .we     (ctrl.reg_write & reset),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd     (rd),
    .wdata  (wb_data),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  assign alu_b = ctrl.alu_src_imm ? (ctrl.imm_s ? imm_s : imm_i) : rs2_data;

  alu alu_0 (
    .a      (rs1_data),
    .b      (alu_b),
    .op     (ctrl.alu_op),
    .result (alu_result)
  );

  branch_unit branch_unit_0 (
    .a      (rs1_data),
    .b      (rs2_data),
    .funct3 (funct3),
    .taken  (taken)
  );

  single_cycle_datapath_if #(.AW(DMEM_AW)) dmem_bus ();

  assign dmem_bus.index = alu_result[DMEM_AW+1:2];
  assign dmem_bus.wdata = rs2_data;
  assign dmem_bus.we    = ctrl.mem_write & reset;

  data_mem #(.DEPTH(DMEM_DEPTH)) data_mem_0 (
    .clock (clock),
    .bus   (dmem_bus.slave)
  );

  assign pc_plus4    = pc + 32'd4;
  assign jalr_target = (rs1_data + imm_i) & ~32'd1;

  always_comb begin
    wb_data = alu_result;
    unique case (ctrl.wb_sel)
      WB_ALU:   wb_data = alu_result;
      WB_MEM:   wb_data = dmem_bus.rdata;
      WB_LINK:  wb_data = pc_plus4;
      WB_IMMU:  wb_data = imm_u;
      WB_AUIPC: wb_data = pc + imm_u;
      default:  wb_data = alu_result;
    endcase
  end

  // JAL with a zero offset targets itself, which is how programs halt.
  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.is_jal)                pc_next = pc + imm_j;
    else if (ctrl.is_jalr)          pc_next = jalr_target;
    else if (ctrl.is_branch && taken) pc_next = pc + imm_b;
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset) pc <= '0;
    else        pc <= pc_next;
  end
endmodule

// File: tb/tb_single_cycle_datapath.sv
// Bench for single_cycle_datapath: an instruction-level RV32I model runs in
// lock-step with the core over directed and randomized programs.
module tb_single_cycle_datapath;
  localparam int IMEM = 256;
  localparam int DMEM = 256;
  localparam logic [31:0] X0_JUNK = 32'hDEADBEEF;
  localparam logic [31:0] HALT    = 32'h0000006F;

  logic clock = 1'b0;
  logic reset = 1'b0;

  single_cycle_datapath #(.IMEM_DEPTH(IMEM), .DMEM_DEPTH(DMEM)) dut (
    .clock (clock),
    .reset (reset)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_imem [IMEM];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [DMEM];
  logic [31:0] m_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] alu_model(logic [2:0] f3, logic alt, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, res, npc, addr;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic        wr, tk;
    ins = m_imem[m_pc[9:2]];
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
    rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
    a  = (rs1 == 0) ? 32'd0 : m_regs[rs1];
    b  = (rs2 == 0) ? 32'd0 : m_regs[rs2];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'd0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    wr = 1'b0; res = 32'd0; npc = m_pc + 32'd4;
    case (op)
      7'b0110011:
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          wr = 1'b1; res = alu_model(f3, f7[5], a, b);
        end
      7'b0010011:
        if (f3 == 3'd1 ? (f7 == 7'h00) : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1) begin
          wr = 1'b1; res = alu_model(f3, f3 == 3'd5 && f7[5], a, ii);
        end
      7'b0000011:
        if (f3 == 3'd2) begin
          addr = a + ii; wr = 1'b1; res = m_dmem[addr[9:2]];
        end
      7'b0100011:
        if (f3 == 3'd2) begin
          addr = a + is; m_dmem[addr[9:2]] = b;
        end
      7'b1100011: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = $signed(a) < $signed(b);
          3'd5: tk = $signed(a) >= $signed(b);
          3'd6: tk = a < b;
          3'd7: tk = a >= b;
          default: tk = 1'b0;
        endcase
        if (tk) npc = m_pc + ib;
      end
      7'b1101111: begin wr = 1'b1; res = m_pc + 32'd4; npc = m_pc + ij; end
      7'b1100111:
        if (f3 == 3'd0) begin
          wr = 1'b1; res = m_pc + 32'd4; npc = (a + ii) & ~32'd1;
        end
      7'b0110111: begin wr = 1'b1; res = iu; end
      7'b0010111: begin wr = 1'b1; res = m_pc + iu; end
      default: ;
    endcase
    if (wr && rd != 0) m_regs[rd] = res;
    m_pc = npc;
  endtask

  // ---------------- bench plumbing ----------------
  task automatic clear_model();
    for (int i = 0; i < IMEM; i++) m_imem[i] = HALT;
    for (int i = 0; i < 32; i++)   m_regs[i] = 32'd0;
    for (int i = 0; i < DMEM; i++) m_dmem[i] = 32'd0;
    m_regs[0] = X0_JUNK;
    m_pc = 32'd0;
  endtask

  task automatic load_dut();
    for (int i = 0; i < IMEM; i++) dut.inst_mem_0.memory[i] = m_imem[i];
    for (int i = 0; i < 32; i++)   dut.reg_file_0.registers[i] = m_regs[i];
    for (int i = 0; i < DMEM; i++) dut.data_mem_0.memory[i] = m_dmem[i];
  endtask

  task automatic compare_state(input string tag);
    check({tag, " pc"}, dut.pc, m_pc);
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (dut.reg_file_0.registers[r] !== m_regs[r]) begin
        errors++;
        $display("FAIL %s x%0d: got %h expected %h", tag, r, dut.reg_file_0.registers[r], m_regs[r]);
      end
    end
    for (int i = 0; i < DMEM; i++) begin
      checks++;
      if (dut.data_mem_0.memory[i] !== m_dmem[i]) begin
        errors++;
        $display("FAIL %s dmem[%0d]: got %h expected %h", tag, i, dut.data_mem_0.memory[i], m_dmem[i]);
      end
    end
  endtask

  // Called at a negedge with reset held: preload, confirm reset PC, release.
  task automatic start_program();
    load_dut();
    m_pc = 32'd0;
    check("reset pc", dut.pc, 32'd0);
    reset = 1'b1;
  endtask

  task automatic hold_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      model_step();
      @(posedge clock);
      @(negedge clock);
      compare_state(tag);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [2:0]  r_f3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    logic        r_alt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  i_f3 [9]  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd5, 3'd5};
    logic [2:0]  b_f3 [6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [6:0]  junk [5]  = '{7'b0000000, 7'b0001111, 7'b1110011, 7'b1111111, 7'b0101011};
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] r, off;
    logic [11:0] imm;
    int          sel;
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); r = $urandom;
    off = 32'(($urandom_range(0, 32) - 16) * 4);
    case ($urandom_range(0, 15))
      0, 1, 2, 15: begin
        sel = $urandom_range(0, 9);
        return enc_r(r_alt[sel] ? 7'h20 : 7'h00, rs2, rs1, r_f3[sel], rd);
      end
      3, 4, 5: begin
        sel = $urandom_range(0, 8);
        imm = r[11:0];
        if (sel == 6) imm = {7'h00, r[4:0]};
        if (sel == 7) imm = {7'h00, r[4:0]};
        if (sel == 8) imm = {7'h20, r[4:0]};
        return enc_i(imm, rs1, i_f3[sel], rd, 7'b0010011);
      end
      6:      return enc_i(r[11:0], rs1, 3'd2, rd, 7'b0000011);
      7:      return enc_s(r[11:0], rs2, rs1);
      8, 9:   return enc_b(off[12:0], rs2, rs1, b_f3[$urandom_range(0, 5)]);
      10:     return enc_j(off[20:0], rd);
      11:     return enc_i(r[11:0], rs1, 3'd0, rd, 7'b1100111);
      12:     return {r[31:12], rd, 7'b0110111};
      13:     return {r[31:12], rd, 7'b0010111};
      default: return {r[31:7], junk[$urandom_range(0, 4)]};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);

    // Stack-frame prologue: addi sp,-32 / sw s0,44(sp) / addi s0,sp,48.
    clear_model();
    m_regs[2] = 32'd100; m_regs[8] = 32'd700;
    m_imem[0] = 32'hFE010113; m_imem[1] = 32'h02812623; m_imem[2] = 32'h03010413;
    start_program();
    run(3, "prologue");
    check("prologue x2", dut.reg_file_0.registers[2], 32'd68);
    check("prologue dmem28", dut.data_mem_0.memory[28], 32'd700);
    check("prologue x8", dut.reg_file_0.registers[8], 32'd116);
    run(5, "halt");
    check("halt pc", dut.pc, 32'h0000000C);

    // x0 discipline and SUB wrap-around.
    hold_reset();
    clear_model();
    m_regs[3] = 32'h1234; m_regs[14] = 32'd5; m_regs[15] = 32'd10;
    m_imem[0] = 32'h00500013; m_imem[1] = 32'h000001B3; m_imem[2] = 32'h40F70833;
    start_program();
    run(4, "x0sub");
    check("x0 add x3", dut.reg_file_0.registers[3], 32'd0);
    check("sub x16", dut.reg_file_0.registers[16], 32'hFFFFFFFB);
    check("x0 slot kept", dut.reg_file_0.registers[0], X0_JUNK);

    // Countdown loop with BNE back-edge, then halt.
    hold_reset();
    clear_model();
    m_imem[0] = 32'h00300293; m_imem[1] = 32'hFFF28293; m_imem[2] = 32'hFE029EE3;
    start_program();
    run(9, "loop");
    check("loop x5", dut.reg_file_0.registers[5], 32'd0);
    check("loop pc", dut.pc, 32'h0000000C);

    // Randomized programs with an asynchronous reset mid-run.
    for (int p = 0; p < 3; p++) begin
      hold_reset();
      clear_model();
      for (int i = 0; i < IMEM; i++) m_imem[i] = gen_instr();
      for (int i = 1; i < 32; i++)   m_regs[i] = $urandom;
      for (int i = 0; i < DMEM; i++) m_dmem[i] = $urandom;
      start_program();
      run(500, "rand");
      #2 reset = 1'b0;
      #1 m_pc = 32'd0;
      check("async reset pc", dut.pc, 32'd0);
      compare_state("async reset");
      @(posedge clock);
      @(negedge clock);
      compare_state("reset held");
      reset = 1'b1;
      run(500, "rand restart");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
